// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_ctrl
// Description : NCH-channel frame-aligned PWM generator with preset select.
//               Define SLEW_LIMIT_EN to ramp each duty toward its preset by
//               at most STEP per frame; otherwise duties jump at the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl #(
  parameter int NCH    = 3,
  parameter int CNT_W  = 26,
  parameter int PERIOD = 2000000,
  parameter int SEL_W  = 2,
  parameter int STEP   = 500
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              manual_on,
  input  logic [SEL_W-1:0]                  sw,
  input  logic [SEL_W-1:0]                  rpi,
  input  logic [NCH*CNT_W*(2**SEL_W)-1:0]   preset_tbl,
  output logic [NCH-1:0]                    out,
  output logic                              frame_tick,
  output logic                              busy
);

  localparam logic [CNT_W:0]   c_period = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W-1:0] c_last   = CNT_W'(PERIOD-1);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  if (STEP < 1) begin : g_step_chk
    $error("pwm_ramp_ctrl: STEP must be >= 1");
  end

  function automatic logic [CNT_W:0] f_clamp(input logic [CNT_W-1:0] v);
    return ({1'b0, v} > c_period) ? c_period : {1'b0, v};
  endfunction

  // Select path: source mux followed by a two-flop synchroniser
  logic [SEL_W-1:0] w_sel_raw;
  logic [SEL_W-1:0] r_sync1;
  logic [SEL_W-1:0] r_sel_s;

  assign w_sel_raw = manual_on ? sw : rpi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sel_s <= '0;
    end else begin
      r_sync1 <= w_sel_raw;
      r_sel_s <= r_sync1;
    end
  end

  // Frame counter; r_tick is high exactly while r_cnt == PERIOD-1
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_tick;

  assign w_cnt_next = r_tick ? '0 : (r_cnt + c_one);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= (w_cnt_next == c_last);
    end
  end

  assign frame_tick = r_tick;

  logic [NCH-1:0] w_out_next;
`ifdef SLEW_LIMIT_EN
  logic [NCH-1:0] w_neq;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [CNT_W-1:0] w_entry_sel;
    logic [CNT_W-1:0] w_entry_rst;
    logic [CNT_W:0]   r_cur;
    logic [CNT_W:0]   r_tgt;
    logic [CNT_W:0]   w_step_val;
    logic [CNT_W:0]   w_cur_next;
    logic [CNT_W:0]   w_tgt_next;

    assign w_entry_sel = preset_tbl[(int'(r_sel_s)*NCH + c)*CNT_W +: CNT_W];
    assign w_entry_rst = preset_tbl[c*CNT_W +: CNT_W];

`ifdef SLEW_LIMIT_EN
    localparam logic [CNT_W:0] c_step = (CNT_W+1)'(STEP);

    // Step toward the target held before this tick; snap when within STEP
    always_comb begin
      w_step_val = r_cur;
      if (r_tgt > r_cur) begin
        if ((r_tgt - r_cur) <= c_step) w_step_val = r_tgt;
        else                           w_step_val = r_cur + c_step;
      end else if (r_cur > r_tgt) begin
        if ((r_cur - r_tgt) <= c_step) w_step_val = r_tgt;
        else                           w_step_val = r_cur - c_step;
      end
    end

    assign w_neq[c] = (r_cur != r_tgt);
`else
    assign w_step_val = r_tgt;
`endif

    assign w_cur_next = r_tick ? w_step_val : r_cur;
    assign w_tgt_next = r_tick ? f_clamp(w_entry_sel) : r_tgt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cur <= f_clamp(w_entry_rst);
        r_tgt <= f_clamp(w_entry_rst);
      end else begin
        r_cur <= w_cur_next;
        r_tgt <= w_tgt_next;
      end
    end

    // Compare against next-cycle values so a new duty starts cleanly at cnt=0
    assign w_out_next[c] = ({1'b0, w_cnt_next} < w_cur_next);
  end

  logic [NCH-1:0] r_out;

  always_ff @(posedge clk) begin
    if (rst) r_out <= '0;
    else     r_out <= w_out_next;
  end

  assign out = r_out;

`ifdef SLEW_LIMIT_EN
  logic r_busy;

  always_ff @(posedge clk) begin
    if (rst) r_busy <= 1'b0;
    else     r_busy <= |w_neq;
  end

  assign busy = r_busy;
`else
  assign busy = 1'b0;
`endif

endmodule
`default_nettype wire
